// File: rtl/host_qm_pkg.sv
// Shared constants and helpers for the host multi-queue descriptor buffer.
//   DW_DEF / QN_DEF / DEPTH_DEF : default descriptor width, queue count, depth
//   CNT_W                       : width of the debug counters
//   clog2_min1()                : ceil(log2(n)) clamped to at least 1
package host_qm_pkg;

    localparam int unsigned DW_DEF    = 13;
    localparam int unsigned QN_DEF    = 4;
    localparam int unsigned DEPTH_DEF = 256;
    localparam int unsigned CNT_W     = 16;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/host_queue_ptr.sv
// Pointer pair and occupancy status for one circular queue.
//   clk, rst_n      : clock, synchronous active-low reset
//   wr_inc / rd_inc : advance write / read pointer this cycle
//   flush           : return both pointers to 0 (wins over wr_inc/rd_inc)
//   wr_idx / rd_idx : RAM offset inside the queue's region
//   usedw           : occupancy 0..2^AW
//   empty / full    : occupancy == 0 / occupancy == 2^AW
module host_queue_ptr #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_inc,
    input  logic          rd_inc,
    input  logic          flush,
    output logic [AW-1:0] wr_idx,
    output logic [AW-1:0] rd_idx,
    output logic [AW:0]   usedw,
    output logic          empty,
    output logic          full
);

    localparam logic [AW:0] FULL_VAL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_inc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_inc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // The extra pointer MSB distinguishes full from empty; the difference
    // wraps naturally mod 2^(AW+1).
    assign usedw  = wr_ptr - rd_ptr;
    assign empty  = (usedw == '0);
    assign full   = (usedw == FULL_VAL);
    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

endmodule

// File: rtl/host_multi_queue_management.sv
// Multi-queue descriptor buffer for the host transmit path: QN circular
// queues in one shared RAM, drained under strict priority (queue 0 highest).
//   i_clk, i_rst_n           : clock, synchronous active-low reset
//   iv_descriptor_wdata/qid  : descriptor and target queue, i_descriptor_wr strobe
//   i_descriptor_rd          : pop request
//   iv_queue_flush           : per-queue flush pulse
//   o_descriptor_available   : some queue is non-empty
//   ov_descriptor_rdata/qid  : popped descriptor and source queue (held)
//   o_descriptor_rdata_valid : one-cycle qualifier, 1 cycle after the pop
//   ov_queue_empty/full/usedw: per-queue status
//   ov_debug_*_cnt           : accepted writes / dropped writes / pops
module host_multi_queue_management
    import host_qm_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned QN    = QN_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned QW    = clog2_min1(QN),
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DW-1:0]         iv_descriptor_wdata,
    input  logic [QW-1:0]         iv_descriptor_qid,
    input  logic                  i_descriptor_wr,
    input  logic                  i_descriptor_rd,
    input  logic [QN-1:0]         iv_queue_flush,
    output logic                  o_descriptor_available,
    output logic [DW-1:0]         ov_descriptor_rdata,
    output logic [QW-1:0]         ov_descriptor_qid,
    output logic                  o_descriptor_rdata_valid,
    output logic [QN-1:0]         ov_queue_empty,
    output logic [QN-1:0]         ov_queue_full,
    output logic [QN*(AW+1)-1:0]  ov_queue_usedw,
    output logic [CNT_W-1:0]      ov_debug_wr_cnt,
    output logic [CNT_W-1:0]      ov_debug_drop_cnt,
    output logic [CNT_W-1:0]      ov_debug_rd_cnt
);

    localparam int unsigned     RAM_AW  = QW + AW;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [AW-1:0] wr_idx [QN];
    logic [AW-1:0] rd_idx [QN];
    logic [QN-1:0] wr_inc;
    logic [QN-1:0] rd_inc;

    logic [QW-1:0] grant;
    logic          grant_found;
    logic          qid_ok;
    logic          wr_accept;
    logic          pop;
    logic [RAM_AW-1:0] waddr;
    logic [RAM_AW-1:0] raddr;

    logic [DW-1:0] mem [QN*DEPTH];

    for (genvar q = 0; q < QN; q++) begin : g_queue
        host_queue_ptr #(.AW(AW)) u_ptr (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .wr_inc (wr_inc[q]),
            .rd_inc (rd_inc[q]),
            .flush  (iv_queue_flush[q]),
            .wr_idx (wr_idx[q]),
            .rd_idx (rd_idx[q]),
            .usedw  (ov_queue_usedw[q*(AW+1) +: AW+1]),
            .empty  (ov_queue_empty[q]),
            .full   (ov_queue_full[q])
        );
    end

    // Strict priority: lowest-index non-empty queue wins.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int unsigned q = 0; q < QN; q++) begin
            if (!grant_found && !ov_queue_empty[q]) begin
                grant       = QW'(q);
                grant_found = 1'b1;
            end
        end
    end

    assign o_descriptor_available = grant_found;

    // A flushed granted queue blocks the pop outright; no fallback to the
    // next queue in the same cycle.
    always_comb begin
        qid_ok    = (32'(iv_descriptor_qid) < QN);
        wr_accept = i_descriptor_wr && qid_ok
                    && !ov_queue_full[iv_descriptor_qid]
                    && !iv_queue_flush[iv_descriptor_qid];
        pop       = i_descriptor_rd && grant_found && !iv_queue_flush[grant];
        wr_inc    = wr_accept ? (QN'(1) << iv_descriptor_qid) : '0;
        rd_inc    = pop ? (QN'(1) << grant) : '0;
        waddr     = {iv_descriptor_qid, wr_idx[iv_descriptor_qid]};
        raddr     = {grant, rd_idx[grant]};
    end

    always_ff @(posedge i_clk) begin
        if (wr_accept) mem[waddr] <= iv_descriptor_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ov_descriptor_rdata      <= '0;
            ov_descriptor_qid        <= '0;
            o_descriptor_rdata_valid <= 1'b0;
        end else begin
            o_descriptor_rdata_valid <= pop;
            if (pop) begin
                ov_descriptor_rdata <= mem[raddr];
                ov_descriptor_qid   <= grant;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ov_debug_wr_cnt   <= '0;
            ov_debug_drop_cnt <= '0;
            ov_debug_rd_cnt   <= '0;
        end else begin
            if (wr_accept)                   ov_debug_wr_cnt   <= ov_debug_wr_cnt + CNT_ONE;
            if (i_descriptor_wr && !wr_accept) ov_debug_drop_cnt <= ov_debug_drop_cnt + CNT_ONE;
            if (pop)                         ov_debug_rd_cnt   <= ov_debug_rd_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_host_multi_queue_management.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_host_multi_queue_management;

    localparam int QN    = 4;
    localparam int DEPTH = 256;
    localparam int DW    = 13;
    localparam int QW    = 2;
    localparam int AW    = 8;
    localparam int UW    = AW + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     wdata;
    logic [QW-1:0]     qid;
    logic              wr;
    logic              rd;
    logic [QN-1:0]     flush;
    logic              avail;
    logic [DW-1:0]     rdata;
    logic [QW-1:0]     rqid;
    logic              rvalid;
    logic [QN-1:0]     empty;
    logic [QN-1:0]     full;
    logic [QN*UW-1:0]  usedw;
    logic [15:0]       wr_cnt;
    logic [15:0]       drop_cnt;
    logic [15:0]       rd_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    host_multi_queue_management #(.DW(DW), .QN(QN), .DEPTH(DEPTH)) dut (
        .i_clk                    (clk),
        .i_rst_n                  (rst_n),
        .iv_descriptor_wdata      (wdata),
        .iv_descriptor_qid        (qid),
        .i_descriptor_wr          (wr),
        .i_descriptor_rd          (rd),
        .iv_queue_flush           (flush),
        .o_descriptor_available   (avail),
        .ov_descriptor_rdata      (rdata),
        .ov_descriptor_qid        (rqid),
        .o_descriptor_rdata_valid (rvalid),
        .ov_queue_empty           (empty),
        .ov_queue_full            (full),
        .ov_queue_usedw           (usedw),
        .ov_debug_wr_cnt          (wr_cnt),
        .ov_debug_drop_cnt        (drop_cnt),
        .ov_debug_rd_cnt          (rd_cnt)
    );

    function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int unsigned uw(input int q);
        return int'(usedw[q*UW +: UW]);
    endfunction

    // Reference model: one plain queue per hardware queue.
    int          mq [QN][$];
    bit          m_ok = 0;
    int unsigned m_rdata, m_qid;
    bit          m_valid;
    logic [15:0] m_wr, m_drop, m_rd;
    int          g;
    bit          wacc;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int q = 0; q < QN; q++) mq[q].delete();
            m_rdata = 0; m_qid = 0; m_valid = 0;
            m_wr = 0; m_drop = 0; m_rd = 0;
            m_ok = 1;
        end else begin
            g = -1;
            for (int q = 0; q < QN; q++)
                if (g < 0 && mq[q].size() > 0) g = q;
            // Full-ness is judged before any same-cycle pop.
            wacc = wr && (int'(qid) < QN) && (mq[qid].size() < DEPTH) && !flush[qid];
            m_valid = 0;
            if (rd && g >= 0 && !flush[g]) begin
                m_rdata = mq[g].pop_front();
                m_qid   = g;
                m_valid = 1;
                m_rd    = m_rd + 16'd1;
            end
            if (wr) begin
                if (wacc) begin
                    mq[qid].push_back(int'(wdata));
                    m_wr = m_wr + 16'd1;
                end else begin
                    m_drop = m_drop + 16'd1;
                end
            end
            for (int q = 0; q < QN; q++)
                if (flush[q]) mq[q].delete();
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            bit any;
            any = 0;
            for (int q = 0; q < QN; q++) begin
                if (mq[q].size() > 0) any = 1;
                chk($sformatf("empty[%0d]", q), empty[q], mq[q].size() == 0);
                chk($sformatf("full[%0d]", q), full[q], mq[q].size() == DEPTH);
                chk($sformatf("usedw[%0d]", q), uw(q), mq[q].size());
            end
            chk("available", avail, any);
            chk("valid", rvalid, m_valid);
            chk("rdata", rdata, m_rdata);
            chk("rqid", rqid, m_qid);
            chk("wr_cnt", wr_cnt, m_wr);
            chk("drop_cnt", drop_cnt, m_drop);
            chk("rd_cnt", rd_cnt, m_rd);
        end
    end

    task automatic cyc(input logic r, input logic w, input int q, input int d,
                       input logic p, input logic [QN-1:0] f);
        rst_n = r;
        wr    = w;
        qid   = QW'(q);
        wdata = DW'(d);
        rd    = p;
        flush = f;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; flush = '0; qid = '0; wdata = '0;
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        chk("rst_empty", empty, 4'hF);
        chk("rst_avail", avail, 0);
        chk("rst_valid", rvalid, 0);

        // Pop with nothing available is ignored.
        cyc(1, 0, 0, 0, 1, 0);
        chk("idle_pop_rd_cnt", rd_cnt, 0);
        chk("idle_pop_valid", rvalid, 0);

        // Single write / pop through queue 2.
        cyc(1, 1, 2, 'h0A1, 0, 0);
        chk("t1_usedw2", uw(2), 1);
        chk("t1_avail", avail, 1);
        cyc(1, 0, 0, 0, 1, 0);
        chk("t1_rdata", rdata, 'h0A1);
        chk("t1_qid", rqid, 2);
        chk("t1_valid", rvalid, 1);
        chk("t1_rd_cnt", rd_cnt, 1);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t1_valid_drop", rvalid, 0);
        chk("t1_rdata_hold", rdata, 'h0A1);

        // Priority: q1 drains before q3.
        cyc(1, 1, 3, 'h010, 0, 0);
        cyc(1, 1, 1, 'h020, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        chk("t2_rdata_a", rdata, 'h020);
        chk("t2_qid_a", rqid, 1);
        cyc(1, 0, 0, 0, 1, 0);
        chk("t2_rdata_b", rdata, 'h010);
        chk("t2_qid_b", rqid, 3);

        // Fill q0 and overflow by one.
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(1, 1, 0, i, 0, 0);
        chk("t3_full0", full[0], 1);
        chk("t3_usedw0", uw(0), 256);
        chk("t3_wr_cnt", wr_cnt, 256);
        chk("t3_drop_cnt", drop_cnt, 1);

        // Drain to 5, then stream write+pop every cycle.
        for (int i = 0; i < 251; i++) cyc(1, 0, 0, 0, 1, 0);
        chk("t4_usedw0_pre", uw(0), 5);
        chk("t4_rdata_pre", rdata, 250);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 'h500 + i, 1, 0);
        chk("t4_usedw0", uw(0), 5);
        chk("t4_rdata", rdata, 'h50E);

        // Flush with same-cycle write and pop on the only non-empty queue.
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1, 'h30 + i, 0, 0);
        chk("t5_usedw1_pre", uw(1), 3);
        cyc(1, 1, 1, 'h777, 1, 4'b0010);
        chk("t5_usedw1", uw(1), 0);
        chk("t5_valid", rvalid, 0);
        chk("t5_drop", drop_cnt, 1);
        chk("t5_rd_cnt", rd_cnt, 0);
        chk("t5_avail", avail, 0);

        // Reset mid-stream with a pop in the reset cycle.
        for (int i = 0; i < 10; i++) cyc(1, 1, i % QN, 'h100 + i, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        chk("t6_valid_pre", rvalid, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t6_avail", avail, 0);
        chk("t6_empty", empty, 4'hF);
        chk("t6_full", full, 0);
        chk("t6_usedw", usedw, 0);
        chk("t6_valid", rvalid, 0);
        chk("t6_rdata", rdata, 0);
        chk("t6_qid", rqid, 0);
        chk("t6_cnts", {wr_cnt, drop_cnt} | 32'(rd_cnt), 0);

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/host_multi_queue_management.md
# host_multi_queue_management

Parametrised multi-queue descriptor buffer for the host transmit path. It stores non-TS packet buffer-ID descriptors in QN independent circular queues held in one shared RAM. It returns them to the host transmit scheduler under strict-priority arbitration, with queue 0 as the highest priority. It adds per-queue occupancy, per-queue flush, drop-on-full accounting and a registered 1-cycle read path, none of which the single-FIFO generation provides.

## Interface
- DW, 13: descriptor width (buffer ID).
- QN, 4: number of queues, 1..16.
- DEPTH, 256: entries per queue, power of 2, ≥ 2.
- QW, $clog2(QN) (min 1): queue-ID width, derived.
- AW, $clog2(DEPTH): pointer index width, derived.
- i_clk  in  1  sole clock.
- i_rst_n  in  1  reset; **synchronous, active-low**; sampled on i_clk rising edge.
- iv_descriptor_wdata  in  DW  descriptor to enqueue.
- iv_descriptor_qid  in  QW  target queue of the write.
- i_descriptor_wr  in  1  write strobe, one descriptor per cycle.
- i_descriptor_rd  in  1  pop request.
- iv_queue_flush  in  QN  per-queue flush pulse.
- o_descriptor_available  out  1  at least one queue is non-empty.
- ov_descriptor_rdata  out  DW  popped descriptor.
- ov_descriptor_qid  out  QW  queue the descriptor came from.
- o_descriptor_rdata_valid  out  1  one-cycle pulse qualifying rdata/qid.
- ov_queue_empty  out  QN  per-queue empty.
- ov_queue_full  out  QN  per-queue full.
- ov_queue_usedw  out  QN*(AW+1)  per-queue occupancy, 0..DEPTH; queue q occupies bits [q*(AW+1) +: AW+1].
- ov_debug_wr_cnt / ov_debug_drop_cnt / ov_debug_rd_cnt  out  16 each  accepted writes / dropped writes / completed pops.

## Operation
- Each queue has AW+1-bit wr/rd pointers. RAM address = {qid, ptr[AW-1:0]}. Occupancy = wr_ptr − rd_ptr, computed mod 2^(AW+1).
- empty[q] = (usedw==0); full[q] = (usedw==DEPTH). All flags, usedw and available come from registered state.
- Write: accepted if qid < QN, the queue is not full and the queue is not flushed this cycle. An accepted write stores to RAM, increments wr_ptr and increments wr_cnt. Otherwise the write is dropped with RAM and pointers untouched, and drop_cnt increments.
- Pop arbitration: grant goes to the lowest-index queue with empty=0, using registered flags. An i_descriptor_rd with available=0 is ignored and no counter changes.
- Accepted pop: RAM read at {g, rd_ptr[g]}, rd_ptr[g] increments, and rd_cnt increments when valid pulses.
- Flush q: wr_ptr[q] = rd_ptr[q] = 0 next cycle. Flush overrides a same-cycle write (counted as dropped) and a same-cycle pop of q (no pop, no valid pulse, rd_cnt unchanged). Arbitration does not re-select another queue in that cycle.
- A write and a pop on the same queue in the same cycle both occur and usedw is unchanged. A write into an empty queue is not poppable until the next cycle.
- A write into a full queue that is popped in the same cycle is dropped, because full is taken from registered state.
- Counters wrap modulo 2^16.

## Timing
- Write-to-visible latency is 1 cycle: usedw, empty, full and available update on the edge after the write.
- Read latency is 1 cycle: rd accepted at edge N gives rdata, qid and valid=1 during cycle N+1. rdata and qid hold their value until the next pop; valid is high for exactly one cycle.
- Back-to-back pops every cycle are supported at full throughput.
- Reset (synchronous): all pointers 0, empty = all ones, full = 0, usedw = 0, available = 0, rdata = 0, qid = 0, valid = 0, all counters 0. RAM contents are not reset.
- A reset asserted mid-operation discards all queued descriptors. A pop accepted in the cycle where reset is sampled produces no valid pulse.

## Structure
- Package host_qm_pkg: default DW/QN/DEPTH, the counter width constant (16) and a clog2-min-1 function for QW.
- Sub-module host_queue_ptr, instantiated QN times: wr/rd pointers, flush, usedw, empty/full for one queue.
- Top level contains a priority encoder, an inferred simple dual-port RAM of QN*DEPTH × DW, the output register and the debug counters.

## Test plan
- Reset, then write 0x0A1 to queue 2 → next cycle usedw[2]=1 and available=1. Pop → in the following cycle rdata=0x0A1, qid=2, valid=1; rd_cnt=1.
- Write 0x010 to q3, then 0x020 to q1, then pop twice → outputs in order 0x020/qid1 then 0x010/qid3.
- Fill q0 with 256 entries and write one more → full[0]=1, the 257th write is dropped, drop_cnt=1, wr_cnt=256.
- Pop every cycle while writing q0 every cycle with usedw[0]=5 → usedw stays 5 and the data order is preserved.
- q1 holds 3 entries; assert flush[1] with a same-cycle write to q1 and a pop → usedw[1]=0, no valid pulse, drop_cnt+1.
- Assert reset mid-stream with 10 entries across queues → all outputs return to their reset values the next cycle and available=0.
